// File: rtl/pipe_pkg.sv
// Shared EX/MEM pipeline types: datapath widths, control bundle and the datapath payload
// carried from EX into MEM.
package pipe_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned PC_W       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef struct packed {
        logic branch;
        logic jump;
        logic memRead;
        logic memWrite;
        logic memToReg;
        logic regWrite;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef struct packed {
        logic                  zero;
        logic [DATA_W-1:0]     aluResult;
        logic [DATA_W-1:0]     storeData;
        logic [REG_ADDR_W-1:0] rd;
        logic [PC_W-1:0]       target;
    } exData_t;

    localparam exData_t EXDATA_NOP = '0;

    // A load and a store in the same instruction cannot be issued to memory.
    function automatic logic isLegalCtrl(input ctrl_t c);
        return !(c.memRead && c.memWrite);
    endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_if.sv
// EX/MEM stage boundary: hazard controls and EX results in, MEM-stage view and
// fetch redirect out.
interface ex_mem_pipe_reg_if #(
    parameter int unsigned CNT_W = 16
) ();
    import pipe_pkg::*;

    logic                  stall;
    logic                  flush;
    logic                  valid_in;
    logic                  branch_in;
    logic                  jump_in;
    logic                  memRead_in;
    logic                  memWrite_in;
    logic                  memToReg_in;
    logic                  regWrite_in;
    logic                  zero_in;
    logic [DATA_W-1:0]     alu_result_in;
    logic [DATA_W-1:0]     store_data_in;
    logic [REG_ADDR_W-1:0] rd_in;
    logic [PC_W-1:0]       target_in;

    logic                  valid_out;
    logic                  branch_out;
    logic                  jump_out;
    logic                  memRead_out;
    logic                  memWrite_out;
    logic                  memToReg_out;
    logic                  regWrite_out;
    logic                  zero_out;
    logic [DATA_W-1:0]     alu_result_out;
    logic [DATA_W-1:0]     store_data_out;
    logic [REG_ADDR_W-1:0] rd_out;
    logic [PC_W-1:0]       target_out;
    logic                  pc_src_out;
    logic [CNT_W-1:0]      bubble_count;

    modport master (
        output stall, flush, valid_in, branch_in, jump_in, memRead_in, memWrite_in,
               memToReg_in, regWrite_in, zero_in, alu_result_in, store_data_in,
               rd_in, target_in,
        input  valid_out, branch_out, jump_out, memRead_out, memWrite_out,
               memToReg_out, regWrite_out, zero_out, alu_result_out, store_data_out,
               rd_out, target_out, pc_src_out, bubble_count
    );

    modport slave (
        input  stall, flush, valid_in, branch_in, jump_in, memRead_in, memWrite_in,
               memToReg_in, regWrite_in, zero_in, alu_result_in, store_data_in,
               rd_in, target_in,
        output valid_out, branch_out, jump_out, memRead_out, memWrite_out,
               memToReg_out, regWrite_out, zero_out, alu_result_out, store_data_out,
               rd_out, target_out, pc_src_out, bubble_count
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with hold and synchronous clear; never wraps past all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             hold,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (!hold && inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with stall/flush, illegal-ctrl squash, PC-source resolve
// and a saturating bubble counter.
module ex_mem_pipe_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input logic          clk,
    input logic          reset,
    ex_mem_pipe_reg_if.slave bus
);

    ctrl_t   ctrlIn;
    exData_t dataIn;
    logic    takeReal;

    ctrl_t   ctrlQ,  ctrlD;
    exData_t dataQ,  dataD;
    logic    validQ, validD;

    logic    bubbleInc;
    logic    cntHold;

    assign ctrlIn = '{branch:   bus.branch_in,
                      jump:     bus.jump_in,
                      memRead:  bus.memRead_in,
                      memWrite: bus.memWrite_in,
                      memToReg: bus.memToReg_in,
                      regWrite: bus.regWrite_in};

    assign dataIn = '{zero:      bus.zero_in,
                      aluResult: bus.alu_result_in,
                      storeData: bus.store_data_in,
                      rd:        bus.rd_in,
                      target:    bus.target_in};

    // An invalid or illegal-ctrl instruction enters MEM as a bubble.
    assign takeReal = bus.valid_in && isLegalCtrl(ctrlIn);

    // Next-state select: flush > stall > load.
    always_comb begin
        validD = validQ;
        ctrlD  = ctrlQ;
        dataD  = dataQ;
        if (bus.flush) begin
            validD = 1'b0;
            ctrlD  = CTRL_NOP;
            dataD  = EXDATA_NOP;
        end else if (!bus.stall) begin
            validD = takeReal;
            ctrlD  = takeReal ? ctrlIn : CTRL_NOP;
            dataD  = dataIn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validQ <= 1'b0;
            ctrlQ  <= CTRL_NOP;
            dataQ  <= EXDATA_NOP;
        end else begin
            validQ <= validD;
            ctrlQ  <= ctrlD;
            dataQ  <= dataD;
        end
    end

    assign bubbleInc = bus.flush || (!bus.stall && !takeReal);
    assign cntHold   = bus.stall && !bus.flush;

    sat_counter #(.CNT_W(CNT_W)) u_bubbleCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bubbleInc),
        .hold  (cntHold),
        .clr   (1'b0),
        .count (bus.bubble_count)
    );

    assign bus.valid_out      = validQ;
    assign bus.branch_out     = ctrlQ.branch;
    assign bus.jump_out       = ctrlQ.jump;
    assign bus.memRead_out    = ctrlQ.memRead;
    assign bus.memWrite_out   = ctrlQ.memWrite;
    assign bus.memToReg_out   = ctrlQ.memToReg;
    assign bus.regWrite_out   = ctrlQ.regWrite;
    assign bus.zero_out       = dataQ.zero;
    assign bus.alu_result_out = dataQ.aluResult;
    assign bus.store_data_out = dataQ.storeData;
    assign bus.rd_out         = dataQ.rd;
    assign bus.target_out     = dataQ.target;

    // Fetch redirect is resolved from the registered stage without a further flop.
    assign bus.pc_src_out = validQ && (ctrlQ.jump || (ctrlQ.branch && dataQ.zero));

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg: reset, load, stall/flush, branch resolve,
// illegal ctrl squash and bubble-counter saturation (CNT_W = 4).
module tb_ex_mem_pipe_reg;
    import pipe_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   expCnt;

    ex_mem_pipe_reg_if #(.CNT_W(CNT_W)) bus ();

    ex_mem_pipe_reg #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clearInputs();
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.valid_in      = 1'b0;
        bus.branch_in     = 1'b0;
        bus.jump_in       = 1'b0;
        bus.memRead_in    = 1'b0;
        bus.memWrite_in   = 1'b0;
        bus.memToReg_in   = 1'b0;
        bus.regWrite_in   = 1'b0;
        bus.zero_in       = 1'b0;
        bus.alu_result_in = '0;
        bus.store_data_in = '0;
        bus.rd_in         = '0;
        bus.target_in     = '0;
    endtask

    // One clock edge; tracks the expected bubble count from the inputs seen at the edge.
    task automatic tick();
        @(posedge clk);
        if (reset) expCnt = 0;
        else if (bus.flush || (!bus.stall && (!bus.valid_in || (bus.memRead_in && bus.memWrite_in))))
            if (expCnt < 15) expCnt = expCnt + 1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clearInputs();
        expCnt = 0;
        tick(); tick();
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", bus.valid_out); end
        total++; if (bus.alu_result_out !== 32'h0) begin bad++; $display("FAIL reset_alu got %h want 0", bus.alu_result_out); end
        total++; if (bus.bubble_count !== 4'h0) begin bad++; $display("FAIL reset_bubble got %h want 0", bus.bubble_count); end
        total++; if (bus.pc_src_out !== 1'b0) begin bad++; $display("FAIL reset_pcsrc got %b want 0", bus.pc_src_out); end

        reset = 1'b0;
        bus.valid_in = 1'b1; bus.branch_in = 1'b1; bus.jump_in = 1'b1; bus.memRead_in = 1'b1;
        bus.memToReg_in = 1'b1; bus.regWrite_in = 1'b1; bus.zero_in = 1'b1;
        bus.alu_result_in = '1; bus.store_data_in = '1; bus.rd_in = '1; bus.target_in = '1;
        tick();
        total++; if (bus.valid_out !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got %b want 1", bus.valid_out); end
        total++; if (bus.alu_result_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL pre_reset_alu got %h want ffffffff", bus.alu_result_out); end
        total++; if (bus.pc_src_out !== 1'b1) begin bad++; $display("FAIL pre_reset_pcsrc got %b want 1", bus.pc_src_out); end

        bus.memWrite_in = 1'b1; bus.stall = 1'b1; bus.flush = 1'b1;
        #3 reset = 1'b1;
        #1;
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL async_reset_valid got %b want 0", bus.valid_out); end
        total++; if (bus.alu_result_out !== 32'h0) begin bad++; $display("FAIL async_reset_alu got %h want 0", bus.alu_result_out); end
        total++; if (bus.target_out !== 32'h0) begin bad++; $display("FAIL async_reset_target got %h want 0", bus.target_out); end
        total++; if (bus.rd_out !== 5'd0) begin bad++; $display("FAIL async_reset_rd got %0d want 0", bus.rd_out); end
        total++; if (bus.regWrite_out !== 1'b0) begin bad++; $display("FAIL async_reset_regwrite got %b want 0", bus.regWrite_out); end
        total++; if (bus.pc_src_out !== 1'b0) begin bad++; $display("FAIL async_reset_pcsrc got %b want 0", bus.pc_src_out); end
        total++; if (bus.bubble_count !== 4'h0) begin bad++; $display("FAIL async_reset_bubble got %h want 0", bus.bubble_count); end

        tick();
        reset = 1'b0; bus.flush = 1'b0;
        tick();
        total++; if (bus.valid_out !== 1'b0 || bus.rd_out !== 5'd0) begin bad++; $display("FAIL post_reset_stall valid=%b rd=%0d want 0/0", bus.valid_out, bus.rd_out); end
        total++; if (bus.bubble_count !== 4'h0) begin bad++; $display("FAIL post_reset_stall_bubble got %h want 0", bus.bubble_count); end
        clearInputs();
    endtask

    task automatic test_load();
        clearInputs();
        bus.valid_in = 1'b1; bus.regWrite_in = 1'b1;
        bus.alu_result_in = 32'h0000_1234; bus.rd_in = 5'd7;
        tick();
        total++; if (bus.regWrite_out !== 1'b1) begin bad++; $display("FAIL load_regwrite got %b want 1", bus.regWrite_out); end
        total++; if (bus.alu_result_out !== 32'h0000_1234) begin bad++; $display("FAIL load_alu got %h want 00001234", bus.alu_result_out); end
        total++; if (bus.rd_out !== 5'd7) begin bad++; $display("FAIL load_rd got %0d want 7", bus.rd_out); end
        total++; if (bus.valid_out !== 1'b1) begin bad++; $display("FAIL load_valid got %b want 1", bus.valid_out); end
        total++; if (bus.memWrite_out !== 1'b0 || bus.pc_src_out !== 1'b0) begin bad++; $display("FAIL load_misc memWrite=%b pcsrc=%b want 0/0", bus.memWrite_out, bus.pc_src_out); end
        total++; if (bus.bubble_count !== 4'h0) begin bad++; $display("FAIL load_bubble got %h want 0", bus.bubble_count); end
    endtask

    task automatic test_stall_flush();
        clearInputs();
        bus.valid_in = 1'b1; bus.regWrite_in = 1'b1; bus.rd_in = 5'd3; bus.alu_result_in = 32'hAA;
        tick();
        total++; if (bus.rd_out !== 5'd3) begin bad++; $display("FAIL stall_setup_rd got %0d want 3", bus.rd_out); end
        bus.stall = 1'b1; bus.valid_in = 1'b0; bus.rd_in = 5'd9; bus.alu_result_in = 32'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.rd_out !== 5'd3 || bus.valid_out !== 1'b1 || bus.alu_result_out !== 32'hAA)
                begin bad++; $display("FAIL stall_hold[%0d] rd=%0d valid=%b alu=%h want 3/1/aa", i, bus.rd_out, bus.valid_out, bus.alu_result_out); end
            total++; if (bus.bubble_count !== 4'(expCnt)) begin bad++; $display("FAIL stall_hold_bubble[%0d] got %0d want %0d", i, bus.bubble_count, expCnt); end
        end
        bus.flush = 1'b1;
        tick();
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL flush_valid got %b want 0", bus.valid_out); end
        total++; if (bus.regWrite_out !== 1'b0 || bus.rd_out !== 5'd0 || bus.alu_result_out !== 32'h0)
            begin bad++; $display("FAIL flush_fields regWrite=%b rd=%0d alu=%h want 0/0/0", bus.regWrite_out, bus.rd_out, bus.alu_result_out); end
        total++; if (bus.bubble_count !== 4'h1) begin bad++; $display("FAIL flush_bubble got %0d want 1", bus.bubble_count); end
    endtask

    task automatic test_branch();
        clearInputs();
        bus.valid_in = 1'b1; bus.branch_in = 1'b1; bus.zero_in = 1'b1; bus.target_in = 32'h40;
        tick();
        total++; if (bus.pc_src_out !== 1'b1) begin bad++; $display("FAIL branch_taken_pcsrc got %b want 1", bus.pc_src_out); end
        total++; if (bus.target_out !== 32'h40) begin bad++; $display("FAIL branch_taken_target got %h want 40", bus.target_out); end
        bus.zero_in = 1'b0;
        tick();
        total++; if (bus.pc_src_out !== 1'b0) begin bad++; $display("FAIL branch_not_taken_pcsrc got %b want 0", bus.pc_src_out); end
        total++; if (bus.target_out !== 32'h40 || bus.branch_out !== 1'b1) begin bad++; $display("FAIL branch_not_taken_fields target=%h branch=%b want 40/1", bus.target_out, bus.branch_out); end
        bus.branch_in = 1'b0; bus.jump_in = 1'b1; bus.target_in = 32'h80;
        tick();
        total++; if (bus.pc_src_out !== 1'b1 || bus.jump_out !== 1'b1) begin bad++; $display("FAIL jump_pcsrc pcsrc=%b jump=%b want 1/1", bus.pc_src_out, bus.jump_out); end
        bus.valid_in = 1'b0;
        tick();
        total++; if (bus.pc_src_out !== 1'b0 || bus.jump_out !== 1'b0 || bus.valid_out !== 1'b0)
            begin bad++; $display("FAIL invalid_jump pcsrc=%b jump=%b valid=%b want 0/0/0", bus.pc_src_out, bus.jump_out, bus.valid_out); end
        total++; if (bus.target_out !== 32'h80) begin bad++; $display("FAIL invalid_jump_target got %h want 80", bus.target_out); end
        total++; if (bus.bubble_count !== 4'h2) begin bad++; $display("FAIL invalid_bubble got %0d want 2", bus.bubble_count); end
    endtask

    task automatic test_illegal();
        clearInputs();
        bus.valid_in = 1'b1; bus.memRead_in = 1'b1; bus.memWrite_in = 1'b1; bus.regWrite_in = 1'b1; bus.rd_in = 5'd12;
        tick();
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL illegal_valid got %b want 0", bus.valid_out); end
        total++; if (bus.memRead_out !== 1'b0 || bus.memWrite_out !== 1'b0 || bus.regWrite_out !== 1'b0)
            begin bad++; $display("FAIL illegal_ctrl rd=%b wr=%b rw=%b want 0/0/0", bus.memRead_out, bus.memWrite_out, bus.regWrite_out); end
        total++; if (bus.bubble_count !== 4'h3) begin bad++; $display("FAIL illegal_bubble got %0d want 3", bus.bubble_count); end
        bus.memWrite_in = 1'b0;
        tick();
        total++; if (bus.valid_out !== 1'b1 || bus.memRead_out !== 1'b1 || bus.rd_out !== 5'd12)
            begin bad++; $display("FAIL legal_load valid=%b memRead=%b rd=%0d want 1/1/12", bus.valid_out, bus.memRead_out, bus.rd_out); end
        total++; if (bus.bubble_count !== 4'(expCnt)) begin bad++; $display("FAIL legal_load_bubble got %0d want %0d", bus.bubble_count, expCnt); end
    endtask

    task automatic test_saturation();
        clearInputs();
        bus.valid_in = 1'b1; bus.flush = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        total++; if (bus.bubble_count !== 4'hF) begin bad++; $display("FAIL sat_flush got %h want f", bus.bubble_count); end
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL sat_valid got %b want 0", bus.valid_out); end
        bus.flush = 1'b0; bus.valid_in = 1'b0;
        tick();
        total++; if (bus.bubble_count !== 4'hF) begin bad++; $display("FAIL sat_no_wrap got %h want f", bus.bubble_count); end
        bus.flush = 1'b1; bus.stall = 1'b1;
        #3 reset = 1'b1;
        #1;
        total++; if (bus.bubble_count !== 4'h0) begin bad++; $display("FAIL reset_mid_flush got %h want 0", bus.bubble_count); end
        tick();
        reset = 1'b0;
        tick();
        total++; if (bus.bubble_count !== 4'h1 || bus.valid_out !== 1'b0) begin bad++; $display("FAIL post_reset_flush bubble=%h valid=%b want 1/0", bus.bubble_count, bus.valid_out); end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        expCnt = 0;
        reset  = 1'b1;
        clearInputs();
        test_reset();
        test_load();
        test_stall_flush();
        test_branch();
        test_illegal();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
